irq_scheduler: RTL

- Interrupt scheduler for the single-cycle CPU.
- Collects one internal periodic-timer source and three external edge-triggered sources, latches them as pending, and applies a mask register.
- Selects the highest-priority unmasked source and runs a request/service/finish handshake with the datapath's interruption and stack logic.
- Its int_req output drives the datapath's timer-interrupt input.

---
 rtl/irq_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/irq_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_scheduler: periodic timer + 3 edge sources, masked fixed-priority     |
// | selection and request/service/finish handshake with the CPU datapath.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module irq_scheduler #(
  parameter int               TIMER_W  = 16,
  parameter int               VEC_W    = 10,
  parameter logic [VEC_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ext_irq,
  input  logic               mask_we,
  input  logic [3:0]         mask_in,
  input  logic               timer_we,
  input  logic [TIMER_W-1:0] timer_load,
  input  logic               in_service,
  input  logic               finish,
  output logic               int_req,
  output logic [VEC_W-1:0]   vector,
  output logic [1:0]         active_id,
  output logic [3:0]         pending,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_ext_prev;
  logic               r_armed;
  logic [3:0]         r_pending;
  logic [3:0]         r_mask;
  logic [TIMER_W-1:0] r_reload;
  logic [TIMER_W-1:0] r_counter;
  logic [1:0]         r_active_id;
  logic [VEC_W-1:0]   r_vector;

  logic [2:0]         w_ext_rise;
  logic               w_tmr_evt;
  logic [3:0]         w_set;
  logic [3:0]         w_clr;
  logic [3:0]         w_sel;
  logic               w_select;
  logic               w_ack;
  logic [1:0]         w_win_id;

  // r_armed suppresses edges on the first cycle after reset, so a source
  // already high at reset release is not mistaken for a new event.
  assign w_ext_rise = r_armed ? (ext_irq & ~r_ext_prev) : 3'b000;
  assign w_tmr_evt  = !timer_we && (r_reload != '0) && (r_counter == TIMER_W'(1));
  assign w_set      = {w_ext_rise, w_tmr_evt};
  assign w_ack      = (r_state == S_REQ) && in_service;
  assign w_clr      = w_ack ? (4'b0001 << r_active_id) : 4'b0000;
  assign w_sel      = r_pending & r_mask;
  assign w_select   = (r_state == S_IDLE) && (w_sel != 4'b0000);

  always_comb begin
    w_win_id = 2'd3;
    if (w_sel[0])      w_win_id = 2'd0;
    else if (w_sel[1]) w_win_id = 2'd1;
    else if (w_sel[2]) w_win_id = 2'd2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext_prev <= 3'b000;
      r_armed    <= 1'b0;
    end else begin
      r_ext_prev <= ext_irq;
      r_armed    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reload  <= '0;
      r_counter <= '0;
    end else if (timer_we) begin
      r_reload  <= timer_load;
      r_counter <= timer_load;
    end else if (r_reload != '0) begin
      r_counter <= w_tmr_evt ? r_reload : r_counter - TIMER_W'(1);
    end
  end

  // Set beats clear so an event racing the acknowledge is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 4'b0000;
      r_mask    <= 4'b0000;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (mask_we) r_mask <= mask_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active_id <= 2'd0;
      r_vector    <= VEC_BASE;
    end else if (w_select) begin
      r_active_id <= w_win_id;
      r_vector    <= VEC_BASE + VEC_W'({w_win_id, 2'b00});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_select) w_state_nxt = S_REQ;
      S_REQ:     if (in_service) w_state_nxt = S_SERVICE;
      S_SERVICE: if (finish) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign int_req   = (r_state == S_REQ);
  assign busy      = (r_state != S_IDLE);
  assign vector    = r_vector;
  assign active_id = r_active_id;
  assign pending   = r_pending;

endmodule
`default_nettype wire
